matrix_frame_source: RTL and testbench

//  Double-buffered frame store and pixel streamer feeding the HUB75 scan driver.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_frame_source_if.sv | 29 ++
 rtl/matrix_beat_fifo.sv | 62 ++++++
 rtl/matrix_frame_source.sv | 144 ++++++++++++++
 tb/tb_matrix_frame_source.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_pkg                                                           |
// | Panel geometry, pixel and beat types shared by the frame source.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package matrix_pkg;
    localparam int PANEL_W   = 64;
    localparam int PANEL_H   = 64;
    localparam int SCAN_ROWS = PANEL_H / 2;
    localparam int COL_W     = $clog2(PANEL_W);
    localparam int ROW_W     = $clog2(SCAN_ROWS);

    typedef logic [2:0] rgb_t;

    typedef struct packed {
        rgb_t             rgb1;
        rgb_t             rgb2;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic             row_last;
        logic             frame_last;
    } pix_beat_t;
endpackage
`default_nettype wire

// File: rtl/matrix_frame_source_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_frame_source_if                                               |
// | Valid/ready pixel-pair stream towards the scan driver.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface matrix_frame_source_if;
    import matrix_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    rgb_t             rgb1;
    rgb_t             rgb2;
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;
    logic             row_last;
    logic             frame_last;

    modport master (
        output pix_valid, rgb1, rgb2, pix_col, pix_row, row_last, frame_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, rgb1, rgb2, pix_col, pix_row, row_last, frame_last,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/matrix_beat_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_beat_fifo                                                     |
// | Two-entry beat FIFO; head drives the stream outputs directly.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module matrix_beat_fifo
    import matrix_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  pix_beat_t  push_beat,
    input  logic       pop,
    output logic       head_valid,
    output pix_beat_t  head_beat,
    output logic [1:0] count
);
    pix_beat_t  entry_q [2];
    pix_beat_t  entry_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            entry_d[wr_ptr_q] = push_beat;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_beat  = entry_q[rd_ptr_q];
    assign count      = count_q;
endmodule
`default_nettype wire

// File: rtl/matrix_frame_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_frame_source                                                  |
// | Double-buffered frame store streaming column-ordered pixel pairs.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module matrix_frame_source
    import matrix_pkg::*;
#(
    parameter int WIDTH  = PANEL_W,
    parameter int HEIGHT = PANEL_H
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [$clog2(WIDTH)-1:0]  wr_x,
    input  logic [$clog2(HEIGHT)-1:0] wr_y,
    input  rgb_t                      wr_rgb,
    input  logic                      swap_req,
    output logic                      swap_pending,
    output logic                      front_bank,
    matrix_frame_source_if.master     pix
);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int RW    = YW - 1;
    localparam int AW    = 1 + RW + XW;
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam logic [XW-1:0] LAST_COL = XW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT / 2 - 1);

    rgb_t mem_top [DEPTH];
    rgb_t mem_bot [DEPTH];

    logic [XW-1:0] rd_col_q, rd_col_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic          in_flight_q, in_flight_d;
    logic          front_bank_q, front_bank_d;
    logic          swap_pending_q, swap_pending_d;
    pix_beat_t     side_q, side_d;
    rgb_t          mem_rd_top_q, mem_rd_bot_q;

    logic          issue, pop, is_row_end, is_frame_end;
    logic [2:0]    occupancy;
    logic [1:0]    fifo_count;
    logic          head_valid;
    pix_beat_t     head_beat, push_beat;
    logic [AW-1:0] wr_addr, rd_addr;

    assign wr_addr = {~front_bank_q, wr_y[RW-1:0], wr_x};
    assign rd_addr = {front_bank_q, rd_row_q, rd_col_q};
    assign pop     = head_valid && pix.pix_ready;

    // Counting the beat leaving this cycle lets a full pipe keep one beat per cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, pop};
    assign issue     = (occupancy < 3'd2);

    always_comb begin
        rd_col_d       = rd_col_q;
        rd_row_d       = rd_row_q;
        in_flight_d    = issue;
        side_d         = side_q;
        front_bank_d   = front_bank_q;
        swap_pending_d = swap_pending_q | swap_req;
        is_row_end     = (rd_col_q == LAST_COL);
        is_frame_end   = is_row_end && (rd_row_q == LAST_ROW);
        if (issue) begin
            rd_col_d          = rd_col_q + 1'b1;
            side_d.rgb1       = '0;
            side_d.rgb2       = '0;
            side_d.col        = rd_col_q;
            side_d.row        = rd_row_q;
            side_d.row_last   = is_row_end;
            side_d.frame_last = is_frame_end;
            if (is_row_end) begin
                rd_row_d = rd_row_q + 1'b1;
            end
            // The frame-end read still uses the old bank; the next one sees the new bank.
            if (is_frame_end && swap_pending_d) begin
                front_bank_d   = ~front_bank_q;
                swap_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_col_q       <= '0;
            rd_row_q       <= '0;
            in_flight_q    <= 1'b0;
            front_bank_q   <= 1'b0;
            swap_pending_q <= 1'b0;
            side_q         <= '0;
        end else begin
            rd_col_q       <= rd_col_d;
            rd_row_q       <= rd_row_d;
            in_flight_q    <= in_flight_d;
            front_bank_q   <= front_bank_d;
            swap_pending_q <= swap_pending_d;
            side_q         <= side_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !wr_y[YW-1]) begin
            mem_top[wr_addr] <= wr_rgb;
        end
        if (wr_en && wr_y[YW-1]) begin
            mem_bot[wr_addr] <= wr_rgb;
        end
        if (issue) begin
            mem_rd_top_q <= mem_top[rd_addr];
            mem_rd_bot_q <= mem_bot[rd_addr];
        end
    end

    always_comb begin
        push_beat      = side_q;
        push_beat.rgb1 = mem_rd_top_q;
        push_beat.rgb2 = mem_rd_bot_q;
    end

    matrix_beat_fifo u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (in_flight_q),
        .push_beat  (push_beat),
        .pop        (pop),
        .head_valid (head_valid),
        .head_beat  (head_beat),
        .count      (fifo_count)
    );

    assign pix.pix_valid  = head_valid;
    assign pix.rgb1       = head_beat.rgb1;
    assign pix.rgb2       = head_beat.rgb2;
    assign pix.pix_col    = head_beat.col;
    assign pix.pix_row    = head_beat.row;
    assign pix.row_last   = head_beat.row_last;
    assign pix.frame_last = head_beat.frame_last;
    assign swap_pending   = swap_pending_q;
    assign front_bank     = front_bank_q;
endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matrix_frame_source                                               |
// | Scoreboard bench: expected beats derived from a model of both banks. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_matrix_frame_source;
    import matrix_pkg::*;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       wr_en    = 1'b0;
    logic [5:0] wr_x     = '0;
    logic [5:0] wr_y     = '0;
    rgb_t       wr_rgb   = '0;
    logic       swap_req = 1'b0;
    logic       swap_pending;
    logic       front_bank;

    matrix_frame_source_if pix();

    matrix_frame_source #(.WIDTH(64), .HEIGHT(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_rgb       (wr_rgb),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_bank   (front_bank),
        .pix          (pix)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          rgb1;
        int          rgb2;
        logic [12:0] side;
    } exp_t;

    int   mem_m [2][64][64];
    exp_t exp_q [$];
    int   model_front, model_pending;
    int   beat_in_frame, frames_seen, total_beats;
    int   ready_mode;
    int   n_checks, n_pass;
    int   seen_c3r8;
    bit   prev_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    function automatic void gen_frame();
        if (model_pending != 0) begin
            model_front   = 1 - model_front;
            model_pending = 0;
        end
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 64; c++) begin
                exp_t e;
                e.rgb1 = mem_m[model_front][r][c];
                e.rgb2 = mem_m[model_front][r+32][c];
                e.side = {6'(c), 5'(r), (c == 63), (c == 63 && r == 31)};
                exp_q.push_back(e);
            end
        end
    endfunction

    // Consumer: compares the head every cycle it is visible, pops on transfer.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check_eq("stall_hold_valid", 32'(pix.pix_valid), 1);
            if (pix.pix_valid) begin
                exp_t e;
                if (exp_q.size() == 0) gen_frame();
                e = exp_q[0];
                check_eq("beat_side", 32'({pix.pix_col, pix.pix_row, pix.row_last, pix.frame_last}), 32'(e.side));
                if (e.rgb1 >= 0) check_eq("beat_rgb1", 32'(pix.rgb1), e.rgb1);
                if (e.rgb2 >= 0) check_eq("beat_rgb2", 32'(pix.rgb2), e.rgb2);
                if (pix.pix_ready) begin
                    void'(exp_q.pop_front());
                    total_beats++;
                    if (pix.pix_col == 6'd3 && pix.pix_row == 5'd8) seen_c3r8 = int'(pix.rgb2);
                    if (e.side[0]) begin
                        beat_in_frame = 0;
                        frames_seen++;
                    end else begin
                        beat_in_frame++;
                    end
                end
            end
            prev_stall = pix.pix_valid && !pix.pix_ready;
        end
    end

    initial begin
        pix.pix_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       pix.pix_ready = 1'b0;
                1:       pix.pix_ready = 1'b1;
                default: pix.pix_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_px(input int bank, input int x, input int y, input int v);
        wr_en  = 1'b1;
        wr_x   = 6'(x);
        wr_y   = 6'(y);
        wr_rgb = 3'(v);
        mem_m[bank][y][x] = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req      = 1'b1;
        model_pending = 1;
        step();
        swap_req = 1'b0;
    endtask

    task automatic wait_in_frame(input int pos, input string tag);
        int n = 0;
        while (beat_in_frame != pos && n < 20000) begin
            step();
            n++;
        end
        check_eq(tag, 32'(beat_in_frame == pos), 1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frames_seen < target && n < 20000) begin
            step();
            n++;
        end
        check_eq(tag, 32'(frames_seen >= target), 1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; ready_mode = 0;
        model_front = 0; model_pending = 0;
        beat_in_frame = 0; frames_seen = 0; total_beats = 0; seen_c3r8 = -1;
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < 64; y++)
                for (int x = 0; x < 64; x++)
                    mem_m[b][y][x] = -1;

        repeat (3) step();
        check_eq("rst_valid",      32'(pix.pix_valid), 0);
        check_eq("rst_rgb",        32'({pix.rgb1, pix.rgb2}), 0);
        check_eq("rst_colrow",     32'({pix.pix_col, pix.pix_row}), 0);
        check_eq("rst_flags",      32'({pix.row_last, pix.frame_last}), 0);
        check_eq("rst_bank_pend",  32'({front_bank, swap_pending}), 0);

        reset = 1'b0;
        step();
        check_eq("lat_valid_c1", 32'(pix.pix_valid), 0);
        step();
        check_eq("lat_valid_c2", 32'(pix.pix_valid), 1);

        // Preload the back bank while the consumer is stalled.
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                write_px(1, x, y, (x + y) % 8);
        pulse_swap();
        check_eq("swap_pending_set", 32'(swap_pending), 1);
        ready_mode = 1;
        wait_frames(1, "wait_frame1");
        wait_in_frame(8, "wait_f1_b8");
        check_eq("front_after_swap1", 32'(front_bank), 1);
        check_eq("pend_after_swap1",  32'(swap_pending), 0);

        // Fill bank 0 while streaming under random back-pressure.
        ready_mode = 2;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                write_px(0, x, y, (x + 2 * y + 3) % 8);

        // Swap requested mid-frame.
        wait_in_frame(100, "wait_t3_b100");
        pulse_swap();
        check_eq("t3_pend_set", 32'(swap_pending), 1);
        wait_in_frame(2000, "wait_t3_b2000");
        check_eq("t3_pend_mid", 32'(swap_pending), 1);
        wait_frames(frames_seen + 1, "wait_t3_end");
        check_eq("t3_pend_clear", 32'(swap_pending), 0);
        check_eq("t3_front",      32'(front_bank), 0);

        // Two requests in one frame give one toggle.
        wait_in_frame(100, "wait_t4_b100");
        pulse_swap();
        wait_in_frame(600, "wait_t4_b600");
        pulse_swap();
        wait_frames(frames_seen + 1, "wait_t4_end");
        check_eq("t4_front", 32'(front_bank), 1);
        wait_in_frame(50, "wait_t4_b50");
        wait_frames(frames_seen + 1, "wait_t4_end2");
        check_eq("t4_single_toggle", 32'(front_bank), 1);

        // Back-bank write during display, visible only after the swap.
        wait_in_frame(200, "wait_t5_b200");
        write_px(0, 3, 40, 5);
        wait_in_frame(300, "wait_t5_b300");
        pulse_swap();
        wait_frames(frames_seen + 1, "wait_t5_end");
        check_eq("t5_front", 32'(front_bank), 0);
        wait_in_frame(600, "wait_t5_b600");
        check_eq("t5_c3r8_rgb2", 32'(seen_c3r8), 5);

        // Reset mid-row with the FIFO full.
        wait_in_frame(70, "wait_t6_b70");
        ready_mode = 0;
        repeat (4) step();
        check_eq("t6_full_valid", 32'(pix.pix_valid), 1);
        reset = 1'b1;
        exp_q.delete();
        model_front = 0; model_pending = 0; beat_in_frame = 0;
        step();
        check_eq("t6_rst_valid",  32'(pix.pix_valid), 0);
        check_eq("t6_rst_data",   32'({pix.rgb1, pix.rgb2, pix.pix_col, pix.pix_row, pix.row_last, pix.frame_last}), 0);
        check_eq("t6_rst_bank",   32'({front_bank, swap_pending}), 0);
        reset = 1'b0;
        ready_mode = 2;
        wait_in_frame(300, "wait_t6_b300");
        check_eq("t6_front_after", 32'(front_bank), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
